// File: rtl/key_event_scheduler.sv
// key_event_scheduler: debounces N_KEYS raw key pins on a shared scan tick and
// delivers press/release changes round-robin on one valid/ready stream.
// Optional autorepeat is built when KEY_SCAN_AUTOREPEAT_EN is defined.
module key_event_scheduler #(
  parameter int N_KEYS       = 8,
  parameter int CLK_FREQ_KHZ = 100_000,
  parameter int SCAN_MS      = 1,
  parameter int STABLE_TICKS = 10,
  parameter int REPEAT_TICKS = 250
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_KEYS-1:0]         keys_raw,
  output logic [N_KEYS-1:0]         keys_db,
  output logic                      evt_valid,
  input  logic                      evt_ready,
  output logic [$clog2(N_KEYS)-1:0] evt_key,
  output logic                      evt_press,
  output logic                      evt_repeat,
  output logic                      evt_overrun
);

  localparam int KW       = $clog2(N_KEYS);
  localparam int TICK_DIV = CLK_FREQ_KHZ * SCAN_MS;
  localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW       = $clog2(STABLE_TICKS + 1);

  typedef enum logic {IDLE, HOLD} state_t;

  function automatic logic [KW-1:0] next_idx(input logic [KW-1:0] k);
    return (k == KW'(N_KEYS - 1)) ? '0 : k + 1'b1;
  endfunction

  logic [N_KEYS-1:0] sync_p0, sync_p1;
  logic [TW-1:0]     tick_cnt;
  logic              tick;
  logic [CW-1:0]     cnt [N_KEYS];
  logic [N_KEYS-1:0] chg, rep_hit, set, clr;
  logic [N_KEYS-1:0] pend, ptype;
  logic [KW-1:0]     rr_ptr, sel;
  logic              found, load;
  state_t            state, state_nxt;

  // Stage p0/p1: two-flop synchroniser on the raw pins
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= keys_raw;
      sync_p1 <= sync_p0;
    end
  end

  assign tick = (tick_cnt == TW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || tick) tick_cnt <= '0;
    else             tick_cnt <= tick_cnt + 1'b1;
  end

  // A key is accepted on the tick that completes STABLE_TICKS differing samples
  always_comb begin
    chg = '0;
    for (int i = 0; i < N_KEYS; i++)
      chg[i] = tick && (sync_p1[i] != keys_db[i]) && (cnt[i] == CW'(STABLE_TICKS - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      keys_db <= '0;
      for (int i = 0; i < N_KEYS; i++) cnt[i] <= '0;
    end else if (tick) begin
      for (int i = 0; i < N_KEYS; i++) begin
        if (sync_p1[i] == keys_db[i]) begin
          cnt[i] <= '0;
        end else if (chg[i]) begin
          keys_db[i] <= sync_p1[i];
          cnt[i]     <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign set = chg | rep_hit;

  always_comb begin
    clr = '0;
    if (load) clr[sel] = 1'b1;
  end

  // Set wins over a same-cycle load; overwriting an undelivered event is an overrun
  always_ff @(posedge clk) begin
    if (rst) begin
      pend        <= '0;
      ptype       <= '0;
      evt_overrun <= 1'b0;
    end else begin
      pend <= (pend & ~clr) | set;
      for (int i = 0; i < N_KEYS; i++)
        if (set[i]) ptype[i] <= chg[i] ? sync_p1[i] : 1'b1;
      if (|(set & pend & ~clr)) evt_overrun <= 1'b1;
    end
  end

`ifdef KEY_SCAN_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_TICKS + 1);
  logic [RW-1:0]     rcnt [N_KEYS];
  logic [N_KEYS-1:0] prep;

  always_comb begin
    rep_hit = '0;
    for (int i = 0; i < N_KEYS; i++)
      rep_hit[i] = tick && keys_db[i] && !chg[i] && (rcnt[i] == RW'(REPEAT_TICKS - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_KEYS; i++) rcnt[i] <= '0;
      prep       <= '0;
      evt_repeat <= 1'b0;
    end else begin
      if (tick)
        for (int i = 0; i < N_KEYS; i++)
          rcnt[i] <= (chg[i] || !keys_db[i] || rep_hit[i]) ? '0 : rcnt[i] + 1'b1;
      for (int i = 0; i < N_KEYS; i++)
        if (set[i]) prep[i] <= rep_hit[i];
      if (load) evt_repeat <= prep[sel];
    end
  end
`else
  // Repeat never fires in this build
  assign rep_hit    = {N_KEYS{REPEAT_TICKS < 0}};
  assign evt_repeat = 1'b0;
`endif

  // Round-robin pick: first pending key at or after rr_ptr, wrapping
  always_comb begin
    logic [KW:0]   j;
    logic [KW-1:0] idx;
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < N_KEYS; k++) begin
      j = {1'b0, rr_ptr} + (KW+1)'(k);
      if (j >= (KW+1)'(N_KEYS)) j = j - (KW+1)'(N_KEYS);
      idx = j[KW-1:0];
      if (!found && pend[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: if (found) begin
        load      = 1'b1;
        state_nxt = HOLD;
      end
      HOLD: if (evt_ready) begin
        if (found) load = 1'b1;
        else       state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign evt_valid = (state == HOLD);

  always_ff @(posedge clk) begin
    if (rst) begin
      evt_key   <= '0;
      evt_press <= 1'b0;
      rr_ptr    <= '0;
    end else if (load) begin
      evt_key   <= sel;
      evt_press <= ptype[sel];
      rr_ptr    <= next_idx(sel);
    end
  end

endmodule
